// File: rtl/commit_buffer_pkg.sv
// Shared types for the in-order commit buffer: dispatch entries, execution results,
// retire outputs and the retire FSM encoding.
package commit_buffer_pkg;

   localparam int ID_W   = 7;
   localparam int DEST_W = 5;
   localparam int DATA_W = 32;
   localparam int PC_W   = 16;

   // CommitEntry and Result use opposite kind encodings
   localparam logic KIND_WB         = 1'b0;
   localparam logic KIND_BRANCH     = 1'b1;
   localparam logic RES_KIND_BRANCH = 1'b0;
   localparam logic RES_KIND_WB     = 1'b1;

   typedef struct packed {
      logic              kind;
      logic              fin;
      logic [1:0]        notify;
      logic [DEST_W-1:0] dest_logic;
      logic [DATA_W-1:0] wb_data;
      logic [PC_W-1:0]   current_pc;
      logic [PC_W-1:0]   new_pc;
      logic              raise;
      logic              taken;
   } commit_entry_t;

   typedef struct packed {
      logic              en;
      logic              kind;
      logic [ID_W-1:0]   commit_id;
      logic [DATA_W-1:0] data;
      logic              raise;
      logic              taken;
      logic [PC_W-1:0]   new_pc;
   } result_t;

   typedef struct packed {
      logic              en;
      logic [DEST_W-1:0] dest_logic;
      logic [DATA_W-1:0] data;
   } commit_info_t;

   typedef struct packed {
      logic              en;
      logic              miss;
      logic              taken;
      logic [PC_W-1:0]   current_pc;
      logic [DATA_W-1:0] jump_addr;
   } branch_result_t;

   typedef enum logic {
      RUN    = 1'b0,
      NOTIFY = 1'b1
   } commit_state_e;

   function automatic logic [DATA_W-1:0] pc_to_addr(input logic [PC_W-1:0] pc);
      return DATA_W'(pc);
   endfunction

endpackage

// File: rtl/commit_buffer.sv
// In-order commit (reorder) buffer: dispatch pushes entries, execution results mark them
// finished, and the head retires in program order to the register file or branch unit.
//
// state  | meaning
// RUN    | retire the head entry as soon as it is valid and finished
// NOTIFY | head wb entry waits for its side-effect ack before retiring
module commit_buffer
   import commit_buffer_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int NRES  = 3
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_en,
   input  commit_entry_t    push_commit_entry,
   output logic [ID_W-1:0]  push_commit_id,
   output logic             full,
   input  result_t          result [NRES],
   output commit_info_t     commit,
   output branch_result_t   branch,
   output logic [1:0]       notify_req,
   input  logic             notify_ack,
   output logic             flush,
   output logic [PC_W-1:0]  flush_pc
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   commit_state_e      state_q;
   commit_state_e      state_d;
   logic [PTR_W-1:0]   head_q;
   logic [PTR_W-1:0]   tail_q;
   logic [PTR_W-1:0]   head_d;
   logic [PTR_W-1:0]   tail_d;
   logic [DEPTH-1:0]   valid_q;
   commit_entry_t      entries [DEPTH];

   logic [IDX_W-1:0]   head_idx;
   logic [IDX_W-1:0]   tail_idx;
   commit_entry_t      head_e;
   logic               head_ready;
   logic               push_ok;
   logic               retire;

   logic               full_d;
   logic [ID_W-1:0]    commit_id_d;
   commit_info_t       commit_d;
   branch_result_t     branch_d;
   logic [1:0]         notify_d;
   logic               flush_d;
   logic [PC_W-1:0]    flush_pc_d;

   assign head_idx   = head_q[IDX_W-1:0];
   assign tail_idx   = tail_q[IDX_W-1:0];
   assign head_e     = entries[head_idx];
   assign head_ready = valid_q[head_idx] && head_e.fin;

   // A retire at this edge cannot free a slot for a push at the same edge, and
   // nothing is accepted during the flush cycle.
   assign push_ok = push_en && !full && !flush;

   always_comb begin
      state_d    = state_q;
      retire     = 1'b0;
      commit_d   = '0;
      branch_d   = '0;
      notify_d   = '0;
      flush_d    = 1'b0;
      flush_pc_d = '0;
      case (state_q)
         RUN: begin
            if (head_ready) begin
               if (head_e.kind == KIND_WB) begin
                  if (head_e.notify == 2'b00) begin
                     commit_d.en         = 1'b1;
                     commit_d.dest_logic = head_e.dest_logic;
                     commit_d.data       = head_e.wb_data;
                     retire              = 1'b1;
                  end else begin
                     state_d  = NOTIFY;
                     notify_d = head_e.notify;
                  end
               end else begin
                  branch_d.en         = 1'b1;
                  branch_d.miss       = head_e.raise;
                  branch_d.taken      = head_e.taken;
                  branch_d.current_pc = head_e.current_pc;
                  branch_d.jump_addr  = pc_to_addr(head_e.new_pc);
                  retire              = 1'b1;
                  if (head_e.raise) begin
                     flush_d    = 1'b1;
                     flush_pc_d = head_e.new_pc;
                  end
               end
            end
         end
         NOTIFY: begin
            if (notify_ack) begin
               commit_d.en         = 1'b1;
               commit_d.dest_logic = head_e.dest_logic;
               commit_d.data       = head_e.wb_data;
               retire              = 1'b1;
               state_d             = RUN;
            end else begin
               notify_d = notify_req;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (flush_d) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (retire)  head_d = head_q + PTR_W'(1);
         if (push_ok) tail_d = tail_q + PTR_W'(1);
      end
      full_d      = (head_d[IDX_W-1:0] == tail_d[IDX_W-1:0]) && (head_d[IDX_W] != tail_d[IDX_W]);
      commit_id_d = ID_W'(tail_d[IDX_W-1:0]);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= RUN;
         head_q         <= '0;
         tail_q         <= '0;
         full           <= 1'b0;
         push_commit_id <= '0;
         commit         <= '0;
         branch         <= '0;
         notify_req     <= '0;
         flush          <= 1'b0;
         flush_pc       <= '0;
      end else begin
         state_q        <= state_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         full           <= full_d;
         push_commit_id <= commit_id_d;
         commit         <= commit_d;
         branch         <= branch_d;
         notify_req     <= notify_d;
         flush          <= flush_d;
         flush_pc       <= flush_pc_d;
      end
   end

   // Result ports are scanned high to low so the lowest port wins an id collision.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush_d) begin
         valid_q <= '0;
      end else begin
         if (push_ok) begin
            entries[tail_idx] <= push_commit_entry;
            valid_q[tail_idx] <= 1'b1;
         end
         if (!flush) begin
            for (int p = NRES - 1; p >= 0; p--) begin
               if (result[p].en && ((result[p].commit_id >> IDX_W) == '0)
                   && valid_q[result[p].commit_id[IDX_W-1:0]]) begin
                  entries[result[p].commit_id[IDX_W-1:0]].fin <= 1'b1;
                  if (result[p].kind == RES_KIND_WB) begin
                     entries[result[p].commit_id[IDX_W-1:0]].wb_data <= result[p].data;
                  end else begin
                     entries[result[p].commit_id[IDX_W-1:0]].raise  <= result[p].raise;
                     entries[result[p].commit_id[IDX_W-1:0]].taken  <= result[p].taken;
                     entries[result[p].commit_id[IDX_W-1:0]].new_pc <= result[p].new_pc;
                  end
               end
            end
         end
         if (retire) begin
            valid_q[head_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: doc/commit_buffer.md
# commit_buffer

In-order commit (reorder) buffer; slave side of `IPushCommit`. Dispatch pushes one `CommitEntry` per cycle and receives its `commit_id`. Execution units return `Result` records that mark entries finished. The head entry retires in program order: write-back goes to the architectural register file, and branches go to the predictor/fetch, which may raise a full pipeline flush.

## Interface
Parameters:
- `DEPTH`, 32: number of entries; power of two, 2..128.
- `NRES`, 3: number of result ports (ALU, FPU, memory).

Ports (clock is `clk`; reset is `rstn`, asynchronous, active-low):
- `clk` input 1: clock.
- `rstn` input 1: asynchronous active-low reset.
- `push` `IPushCommit.slave`: `en`/`commit_entry` in, `commit_id` out (id the next push receives).
- `full` output 1: no free entry; registered.
- `result` input `Result[NRES]`: completions.
- `commit` output `CommitInfo`: register-file write of the retired wb entry.
- `branch` output `BranchResult`: retired branch (`miss` = raise).
- `notify_req` output 2: side-effect request of head wb entry; bit0 uart, bit1 sw.
- `notify_ack` input 1: side effect done.
- `flush` output 1: pipeline flush pulse.
- `flush_pc` output 16: restart PC, valid with `flush`.

## Operation
Storage:
- Ring of `DEPTH` entries, each holding a `CommitEntry` plus a `valid` bit.
- `head`/`tail` pointers are log2(DEPTH)+1 bits (wrap bit); `commit_id` = zero-extended `tail` index.

Push:
- `push.en && !full` writes the entry at `tail` with `valid=1` and advances `tail`.
- `push.en` while `full` is dropped with no state change.
- An entry pushed with `fin=1` needs no result.

Completion:
- A `Result` with `en=1` whose `commit_id` hits a valid entry sets `fin=1`.
- `Result.kind` 1 (wb): copies `data` into `wb.data`. `Result.kind` 0 (branch): copies `raise`, `taken`, `new_pc`.
- Note the encoding mismatch: `CommitEntry.kind` is 0=wb, 1=branch.
- Results aimed at invalid entries are ignored.
- Two ports with the same id in one cycle is illegal; the lower port index wins.

Retire FSM, states RUN and NOTIFY:
- RUN, head valid, fin=1, wb, `notify==0`: `commit` {en=1, dest_logic, data}; head frees.
- RUN, head valid, fin=1, wb, `notify!=0`: go to NOTIFY, `notify_req=notify`.
- NOTIFY: hold `notify_req` until `notify_ack`; on ack, retire as above, clear `notify_req`, return to RUN.
- RUN, branch, `raise=0`: `branch` {en=1, miss=0, taken, current_pc, jump_addr=new_pc zero-extended}.
- RUN, branch, `raise=1`: the same `branch` with miss=1, plus `flush=1`, `flush_pc=new_pc`. All `valid` bits clear, head=tail=0, FSM returns to RUN.
- At most one retire per cycle.

## Timing
- All outputs are registered. Reset value of every output is 0; `commit_id`=0, `full`=0, FSM=RUN, all entries invalid.
- Result sampled at edge E0; if that entry is head, the retire decision occurs at E1. `commit`/`branch` is high for the one cycle after E1.
- Fastest case is a push with fin=1 into an empty buffer: retire output is visible two cycles after the push cycle.
- `full` and `commit_id` reflect push and retire of the same edge. A retire does not unblock a push in that same cycle.
- Flush cycle:
  - Pushes and results presented in the cycle `flush` is high are ignored.
  - Units must squash on `flush`.
  - `commit_id` reads 0 the following cycle.
- Pointer wrap: index wraps modulo `DEPTH`. `full` is (index equal, wrap bits differ); empty is (pointers equal).
- `notify_ack` sampled outside NOTIFY is ignored.
- `rstn` low mid-operation, including in NOTIFY, immediately clears everything, and outputs drop asynchronously.

## Structure
- No new struct types are needed; uses `CommitEntry`, `Result`, `CommitInfo`, `BranchResult`, `IPushCommit` from the shared bus package.
- Add to the package: FSM enum `CommitState {RUN, NOTIFY}`.
- Single module, no sub-module; entry array held in flops (needed for per-entry `fin` update from `NRES` ports).

## Test plan
- Reset, then push 3 wb entries (dest 1,2,3); results complete ids 2,0,1 with data 0x22,0x00,0x11. Retire must follow id order: commits dest1/0x00, dest2/0x11, dest3/0x22 on consecutive cycles.
- Push 32 entries with fin=0: `full`=1 after the 32nd; a 33rd push is dropped. Complete id 0: one retire, then `full`=0, and the next push gets id 0 (wrap).
- Branch entry at id 5, result raise=1, new_pc=0x0040: `branch.miss`=1, `flush`=1, `flush_pc`=0x0040. Entries 6..9 are never committed; the next push gets id 0.
- Head wb with notify=2'b01, fin=1: `notify_req`=01 held 4 cycles until ack; commit fires the cycle after the ack edge. No younger entry retires earlier.
- Results on ports 0 and 2 in the same cycle for ids 0 and 1: both retire on consecutive cycles. A result to an invalid id 20 changes nothing.
- Deassert `rstn` while in NOTIFY with 10 valid entries: all outputs 0, `commit_id`=0, `full`=0; no commit after reset release.
